// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
// Compile-time option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// reads (head word shown combinationally, rd_en pops it). Without the macro
// rd_data is registered with one cycle of read latency.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              overflow_q, underflow_q;
    logic              wr_acc, rd_acc;

    // Extra pointer MSB distinguishes full from empty so all DEPTH slots are usable
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[AW] != rptr_q[AW]) &&
                          (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    // Acceptance uses pre-edge flags only: no bypass of a same-cycle read/write
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state pointers
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) wptr_d = wptr_q + ONE;
        if (rd_acc) rptr_d = rptr_q + ONE;
    end

    // Pointer and error-pulse registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage array, intentionally not reset; gated so reset blocks writes
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; rd_en acknowledges it
    assign rd_data  = mem_q[rptr_q[AW-1:0]];
    assign rd_valid = !empty;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read: load head on accepted pop, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rptr_q[AW-1:0]];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed testbench for sync_fifo_param (DEPTH=16, DATA_W=8, AF=14, AE=2).
// Read expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int failures = 0;

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Returns the popped word and the valid seen with it
    task automatic pop(output logic [7:0] d, output logic v);
        rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        d = rd_data; v = rd_valid;
        tick();
`else
        tick();
        d = rd_data; v = rd_valid;
`endif
        rd_en = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] din, output logic [7:0] dout);
        wr_en = 1'b1; wr_data = din; rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        dout = rd_data;
        tick();
`else
        tick();
        dout = rd_data;
`endif
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin failures++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {rd_valid, overflow, underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
`endif
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            push(8'(k));
            checks++; if (count !== 5'(k)) begin failures++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, k); end
            checks++; if (almost_full !== (k >= 14)) begin failures++; $display("FAIL fill_af k=%0d got=%b exp=%b", k, almost_full, k >= 14); end
            checks++; if (almost_empty !== (k <= 2)) begin failures++; $display("FAIL fill_ae k=%0d got=%b exp=%b", k, almost_empty, k <= 2); end
            checks++; if (full !== (k == 16)) begin failures++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, full, k == 16); end
            checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty k=%0d got=%b exp=0", k, empty); end
        end
    endtask

    task automatic test_overflow();
        push(8'hAA);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        logic [7:0] d; logic v;
        for (int k = 1; k <= 16; k++) begin
            pop(d, v);
            checks++; if (d !== 8'(k) || v !== 1'b1) begin failures++; $display("FAIL drain_data k=%0d got=%h/%b exp=%h/1", k, d, v, 8'(k)); end
            checks++; if (count !== 5'(16 - k)) begin failures++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count, 16 - k); end
        end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL drain_flags got=e%b f%b exp=e1 f0", empty, full); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL unf_valid got=%b exp=0", rd_valid); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
        tick();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic v;
        logic [7:0] exp_q [$];
        do_reset();
        for (int i = 0; i < 5; i++) begin push(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i)); end
        for (int i = 0; i < 10; i++) begin
            push_pop(8'h20 + 8'(i), d);
            exp_q.push_back(8'h20 + 8'(i));
            checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, d, exp_q[0]); end
            void'(exp_q.pop_front());
            checks++; if (count !== 5'd5) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=5", i, count); end
        end
        for (int i = 0; i < 5; i++) begin
            pop(d, v);
            checks++; if (d !== 8'h25 + 8'(i)) begin failures++; $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, d, 8'h25 + 8'(i)); end
        end
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        push_pop(8'h77, d);
        checks++; if (d !== 8'h40) begin failures++; $display("FAIL full_rw_data got=%h exp=40", d); end
        checks++; if (count !== 5'd15 || overflow !== 1'b1) begin failures++; $display("FAIL full_rw got=cnt%0d ovf%b exp=cnt15 ovf1", count, overflow); end
        for (int i = 1; i < 16; i++) begin
            pop(d, v);
            checks++; if (d !== 8'h40 + 8'(i)) begin failures++; $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, d, 8'h40 + 8'(i)); end
        end
        push_pop(8'h88, d);
        checks++; if (count !== 5'd1 || underflow !== 1'b1) begin failures++; $display("FAIL empty_rw got=cnt%0d unf%b exp=cnt1 unf1", count, underflow); end
        pop(d, v);
        checks++; if (d !== 8'h88 || count !== 5'd0) begin failures++; $display("FAIL empty_rw_data got=%h cnt%0d exp=88 cnt0", d, count); end
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic v;
        int wn = 0;
        int rn = 0;
        int sizes [3] = '{16, 16, 8};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < sizes[r]; i++) begin wn++; push(8'(wn)); end
            checks++; if (full !== (sizes[r] == 16) || count !== 5'(sizes[r])) begin failures++; $display("FAIL wrap_full r=%0d got=f%b cnt%0d exp=f%b cnt%0d", r, full, count, sizes[r] == 16, sizes[r]); end
            for (int i = 0; i < sizes[r]; i++) begin
                rn++;
                pop(d, v);
                checks++; if (d !== 8'(rn)) begin failures++; $display("FAIL wrap_data n=%0d got=%h exp=%h", rn, d, 8'(rn)); end
            end
            checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL wrap_empty r=%0d got=e%b f%b exp=e1 f0", r, empty, full); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic v;
        do_reset();
        for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
        checks++; if (count !== 5'd9) begin failures++; $display("FAIL mid_pre_count got=%0d exp=9", count); end
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin failures++; $display("FAIL mid_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL mid_pulses got=%b exp=000", {rd_valid, overflow, underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_rd_data got=%h exp=00", rd_data); end
`endif
        push(8'h5C);
        pop(d, v);
        checks++; if (d !== 8'h5C || v !== 1'b1) begin failures++; $display("FAIL mid_readback got=%h/%b exp=5c/1", d, v); end
    endtask

    task automatic test_read_mode();
        do_reset();
        push(8'h33);
`ifdef SYNC_FIFO_FWFT_EN
        checks++; if (rd_data !== 8'h33 || rd_valid !== 1'b1) begin failures++; $display("FAIL fwft_show got=%h/%b exp=33/1", rd_data, rd_valid); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL fwft_pop got=v%b e%b exp=v0 e1", rd_valid, empty); end
`else
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL std_pre got=%h/%b exp=00/0", rd_data, rd_valid); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 8'h33 || rd_valid !== 1'b1) begin failures++; $display("FAIL std_read got=%h/%b exp=33/1", rd_data, rd_valid); end
        tick();
        checks++; if (rd_data !== 8'h33 || rd_valid !== 1'b0) begin failures++; $display("FAIL std_hold got=%h/%b exp=33/0", rd_data, rd_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_read_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
